// File: rtl/exp_adc_pkg.sv
// rtl/exp_adc_pkg.sv - shared constants, FSM states and helpers for the ADC emulator
package exp_adc_pkg;

    localparam logic [1:0] LaneModeOne  = 2'b00;
    localparam logic [1:0] LaneModeTwo  = 2'b01;
    localparam logic [1:0] LaneModeFour = 2'b10;

    localparam logic [2:0]  RegAccessPrefix = 3'b101;
    localparam logic [14:0] ModeReg         = 15'h0020;
    localparam logic [14:0] ExitReg         = 15'h0014;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        READY,
        SHIFT,
        DONE
    } shift_state_e;

    // Mode 2'b11 is kept in lane_mode but shifts like one-lane mode.
    function automatic logic [5:0] lane_step(input logic [1:0] mode);
        case (mode)
            LaneModeTwo:  return 6'd2;
            LaneModeFour: return 6'd4;
            default:      return 6'd1;
        endcase
    endfunction

endpackage

// File: rtl/exp_adc_sync_edge.sv
// rtl/exp_adc_sync_edge.sv - 2-FF synchronizer with registered rise/fall pulses
module exp_adc_sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic aclk,
    input  logic areset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    always_ff @(posedge aclk) begin
        if (areset) begin
            s1    <= INIT;
            s2    <= INIT;
            level <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= d;
            s2    <= s1;
            level <= s2;
            rise  <= s2 & ~level;
            fall  <= ~s2 & level;
        end
    end

endmodule

// File: rtl/exp_adc_emulator.sv
// rtl/exp_adc_emulator.sv - ADC conversion/SPI emulator fed from an AXI Stream sample source
module exp_adc_emulator
    import exp_adc_pkg::*;
#(
    parameter int          CNV_CYCLES     = 14,
    parameter logic [31:0] DEFAULT_SAMPLE = 32'h8BADF00D
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cnv,
    output logic        busy,
    input  logic        sck,
    input  logic        csn,
    input  logic        sdi,
    output logic [3:0]  sdo,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [23:0] reg_command,
    output logic [1:0]  lane_mode,
    output logic        reg_access
);

    localparam int CntW = $clog2(CNV_CYCLES);

    logic cnv_lvl, cnv_rise, cnv_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic csn_lvl, csn_rise, csn_fall;

    exp_adc_sync_edge #(.INIT(1'b0)) u_sync_cnv (
        .aclk(aclk), .areset(areset), .d(cnv), .level(cnv_lvl), .rise(cnv_rise), .fall(cnv_fall)
    );
    exp_adc_sync_edge #(.INIT(1'b0)) u_sync_sck (
        .aclk(aclk), .areset(areset), .d(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    exp_adc_sync_edge #(.INIT(1'b1)) u_sync_csn (
        .aclk(aclk), .areset(areset), .d(csn), .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{cnv_lvl, cnv_fall, sck_lvl, sck_fall};

    shift_state_e    state, state_nxt;
    logic [31:0]     sample;
    logic [5:0]      bit_idx;
    logic            data_ready;
    logic [CntW-1:0] cnv_cnt;
    logic [23:0]     cmd_sr;
    logic            reg_access_nxt;
    logic [1:0]      lane_mode_nxt;
    logic            conv_start, conv_done;
    logic            load_first, shift_step, shift_end, frame_abort;
    logic [31:0]     aligned;
    logic [3:0]      group;

    // Command decode is evaluated first so a same-cycle cnv sees the post-decode mode.
    always_comb begin
        reg_access_nxt = reg_access;
        lane_mode_nxt  = lane_mode;
        if (csn_rise) begin
            if (cmd_sr[23:21] == RegAccessPrefix) begin
                reg_access_nxt = 1'b1;
            end else if (reg_access) begin
                if (cmd_sr[23:8] == {1'b1, ModeReg}) begin
                    lane_mode_nxt = cmd_sr[7:6];
                end else if (cmd_sr[23:8] == {1'b1, ExitReg} && cmd_sr[0]) begin
                    reg_access_nxt = 1'b0;
                end
            end
        end
    end

    assign conv_start = cnv_rise & ~busy & ~reg_access_nxt;
    assign conv_done  = busy && (cnv_cnt == '0);

    // Left-align the next unsent bit so every lane width reads from the top.
    assign aligned = sample << (6'd32 - bit_idx);

    always_comb begin
        case (lane_mode)
            LaneModeFour: group = aligned[31:28];
            LaneModeTwo:  group = {2'b00, aligned[31:30]};
            default:      group = {3'b000, aligned[31]};
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (conv_start) begin
            state_nxt = CONV;
        end else begin
            case (state)
                CONV:    if (conv_done) state_nxt = READY;
                READY:   if (csn_fall && data_ready) state_nxt = SHIFT;
                SHIFT: begin
                    if (csn_rise) state_nxt = IDLE;
                    else if (sck_rise && bit_idx == 6'd0) state_nxt = DONE;
                end
                DONE:    if (csn_rise) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        load_first  = 1'b0;
        shift_step  = 1'b0;
        shift_end   = 1'b0;
        frame_abort = 1'b0;
        if (!conv_start) begin
            case (state)
                READY: load_first = csn_fall && data_ready;
                SHIFT: begin
                    if (csn_rise) frame_abort = 1'b1;
                    else if (sck_rise && bit_idx == 6'd0) shift_end = 1'b1;
                    else if (sck_rise) shift_step = 1'b1;
                end
                DONE:    frame_abort = csn_rise;
                default: load_first = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            busy          <= 1'b0;
            sdo           <= 4'd0;
            s_axis_tready <= 1'b0;
            reg_command   <= 24'd0;
            lane_mode     <= LaneModeOne;
            reg_access    <= 1'b0;
            data_ready    <= 1'b0;
            sample        <= 32'd0;
            bit_idx       <= 6'd0;
            cnv_cnt       <= '0;
            cmd_sr        <= 24'd0;
        end else begin
            s_axis_tready <= 1'b0;

            if (csn_fall) begin
                cmd_sr <= 24'd0;
            end else if (sck_rise && !csn_lvl) begin
                cmd_sr <= {cmd_sr[22:0], sdi};
            end

            if (csn_rise) begin
                reg_command <= cmd_sr;
                reg_access  <= reg_access_nxt;
                lane_mode   <= lane_mode_nxt;
            end

            if (conv_start) begin
                sample        <= s_axis_tvalid ? s_axis_tdata : DEFAULT_SAMPLE;
                s_axis_tready <= s_axis_tvalid;
                busy          <= 1'b1;
                cnv_cnt       <= CntW'(CNV_CYCLES - 1);
                bit_idx       <= 6'd32;
                data_ready    <= 1'b0;
                sdo           <= 4'd0;
            end else begin
                if (conv_done) begin
                    busy       <= 1'b0;
                    data_ready <= 1'b1;
                end else if (busy) begin
                    cnv_cnt <= cnv_cnt - 1'b1;
                end
                if (load_first) begin
                    sdo <= group;
                end
                if (shift_step) begin
                    sdo     <= group;
                    bit_idx <= bit_idx - lane_step(lane_mode);
                end
                if (shift_end || frame_abort) begin
                    sdo        <= 4'd0;
                    data_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_exp_adc_emulator.sv
// tb/tb_exp_adc_emulator.sv - directed self-checking bench for exp_adc_emulator
module tb_exp_adc_emulator;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cnv = 1'b0;
    logic        sck = 1'b0;
    logic        csn = 1'b1;
    logic        sdi = 1'b0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        busy;
    logic [3:0]  sdo;
    logic        s_axis_tready;
    logic [23:0] reg_command;
    logic [1:0]  lane_mode;
    logic        reg_access;

    int n_checks = 0;
    int n_pass = 0;
    int pops = 0;

    always #5 aclk = ~aclk;

    always @(negedge aclk) if (s_axis_tready) pops++;

    exp_adc_emulator dut (
        .aclk(aclk), .areset(areset), .cnv(cnv), .busy(busy),
        .sck(sck), .csn(csn), .sdi(sdi), .sdo(sdo),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .reg_command(reg_command), .lane_mode(lane_mode), .reg_access(reg_access)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_cmd(input logic [23:0] cmd);
        csn = 1'b0;
        cyc(8);
        for (int i = 23; i >= 0; i--) begin
            sdi = cmd[i];
            sck = 1'b1;
            cyc(8);
            sck = 1'b0;
            cyc(8);
        end
        csn = 1'b1;
        sdi = 1'b0;
        cyc(8);
    endtask

    task automatic shift_read(input int n, input int lanes, input logic [31:0] exp, input string tag);
        logic [3:0]  mask;
        logic [31:0] want;
        mask = (lanes == 4) ? 4'hF : (lanes == 2) ? 4'h3 : 4'h1;
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            cyc(8);
            want = (exp >> (32 - lanes * (i + 1))) & {28'd0, mask};
            check($sformatf("%s_g%0d", tag, i), {28'd0, sdo & mask}, want);
            sck = 1'b0;
            cyc(8);
        end
    endtask

    task automatic extra_sck(input string tag);
        sck = 1'b1;
        cyc(8);
        check(tag, {28'd0, sdo}, 32'd0);
        sck = 1'b0;
        cyc(8);
    endtask

    task automatic do_conv(input string tag);
        int n;
        cnv = 1'b1;
        cyc(3);
        check({tag, "_busy_pre"}, {31'd0, busy}, 32'd0);
        cyc(1);
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        cnv = 1'b0;
        n = 1;
        for (int i = 0; i < 100 && busy; i++) begin
            cyc(1);
            if (busy) n++;
        end
        check({tag, "_busy_len"}, n, 32'd14);
    endtask

    initial begin
        int n;
        int p0;

        cyc(4);
        areset = 1'b0;
        cyc(1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sdo", {28'd0, sdo}, 32'd0);
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_cmd", {8'd0, reg_command}, 32'd0);
        check("rst_lane", {30'd0, lane_mode}, 32'd0);
        check("rst_regacc", {31'd0, reg_access}, 32'd0);

        // Default sample, one lane, 33rd edge idles the lane
        do_conv("c1");
        csn = 1'b0;
        cyc(8);
        shift_read(32, 1, 32'h8BADF00D, "one");
        extra_sck("one_after");
        csn = 1'b1;
        cyc(8);
        check("no_pop", pops, 32'd0);

        // Register access sequence then a four-lane read
        s_axis_tdata = 32'h0023FF42;
        s_axis_tvalid = 1'b1;
        send_cmd(24'hA00000);
        check("ra_enter", {31'd0, reg_access}, 32'd1);
        check("cmd_latch", {8'd0, reg_command}, 32'h00A00000);
        send_cmd(24'h802080);
        check("ra_mode", {31'd0, reg_access}, 32'd1);
        check("lane4", {30'd0, lane_mode}, 32'd2);
        send_cmd(24'h801401);
        check("ra_exit", {31'd0, reg_access}, 32'd0);
        do_conv("c2");
        s_axis_tvalid = 1'b0;
        check("pop1", pops, 32'd1);
        csn = 1'b0;
        cyc(8);
        shift_read(8, 4, 32'h0023FF42, "four");
        csn = 1'b1;
        cyc(8);

        // Two lanes
        send_cmd(24'hA00000);
        send_cmd(24'h802040);
        send_cmd(24'h801401);
        check("lane2", {30'd0, lane_mode}, 32'd1);
        s_axis_tdata = 32'hCAFEBABE;
        s_axis_tvalid = 1'b1;
        do_conv("c3");
        s_axis_tvalid = 1'b0;
        csn = 1'b0;
        cyc(8);
        shift_read(16, 2, 32'hCAFEBABE, "two");
        extra_sck("two_17th");
        csn = 1'b1;
        cyc(8);

        // cnv during busy must not retrigger or pop again
        s_axis_tdata = 32'h11111111;
        s_axis_tvalid = 1'b1;
        p0 = pops;
        n = 0;
        cnv = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 3) cnv = 1'b0;
            if (i == 6) cnv = 1'b1;
            if (i == 9) cnv = 1'b0;
            cyc(1);
            if (busy) n++;
        end
        s_axis_tvalid = 1'b0;
        check("retrig_len", n, 32'd14);
        check("retrig_pops", pops - p0, 32'd1);

        // cnv in register mode is ignored
        send_cmd(24'hA00000);
        s_axis_tvalid = 1'b1;
        p0 = pops;
        n = 0;
        cnv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) cnv = 1'b0;
            cyc(1);
            if (busy) n++;
        end
        s_axis_tvalid = 1'b0;
        check("regmode_busy", n, 32'd0);
        check("regmode_pops", pops - p0, 32'd0);
        send_cmd(24'h802000);
        send_cmd(24'h801401);
        check("lane1", {30'd0, lane_mode}, 32'd0);
        check("ra_exit2", {31'd0, reg_access}, 32'd0);

        // Aborted frame discards the rest of the sample
        s_axis_tdata = 32'h9C3E71A5;
        s_axis_tvalid = 1'b1;
        do_conv("c4");
        s_axis_tvalid = 1'b0;
        csn = 1'b0;
        cyc(8);
        shift_read(10, 1, 32'h9C3E71A5, "part");
        csn = 1'b1;
        cyc(8);
        csn = 1'b0;
        cyc(8);
        shift_read(5, 1, 32'd0, "stale");
        csn = 1'b1;
        cyc(8);

        // Reset in the middle of a four-lane frame
        send_cmd(24'hA00000);
        send_cmd(24'h802080);
        send_cmd(24'h801401);
        do_conv("c5");
        csn = 1'b0;
        cyc(8);
        shift_read(3, 4, 32'h8BADF00D, "pre_rst");
        areset = 1'b1;
        cyc(1);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_sdo", {28'd0, sdo}, 32'd0);
        check("mrst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("mrst_cmd", {8'd0, reg_command}, 32'd0);
        check("mrst_lane", {30'd0, lane_mode}, 32'd0);
        check("mrst_regacc", {31'd0, reg_access}, 32'd0);
        areset = 1'b0;
        csn = 1'b1;
        cyc(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
